// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset release sequencer.
//   seq_state_t  : sequencer FSM state encoding (2 bits)
//   STAGE_IDX_W  : width of stage index outputs (cur_stage, fail_stage)
//   DROP_W       : width of the loss-of-ready recovery counter
package reset_seq_pkg;

    localparam int STAGE_IDX_W = 4;
    localparam int DROP_W      = 8;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,   // current stage held in reset for STAGE_DELAY cycles
        WAIT  = 2'd1,   // current stage released, waiting for debounced ready
        DONE  = 2'd2,   // every stage released and ready
        FAULT = 2'd3    // current stage never became ready in time
    } seq_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// Ports:
//   clk    : clock
//   rst_n  : synchronous active-low reset (count -> 0)
//   clr    : synchronous clear, wins over en
//   en     : increment by one, holding at all-ones
//   count  : current count value
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en && (count_reg != {WIDTH{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/reset_sequencer.sv
// Multi-stage reset release sequencer. Stages are released one at a time
// in index order: each is held in reset for STAGE_DELAY cycles, then the
// sequencer waits for its ready input to be high for DEBOUNCE consecutive
// cycles before moving on. Handles per-stage timeout, loss of ready on an
// already-completed stage (re-sequence from the lowest dropped stage) and
// software restart.
// Ports:
//   sys_clk      : sole clock
//   sys_reset_n  : synchronous active-low reset
//   soft_reset   : single-cycle request to restart the whole sequence
//   stage_ready  : per-stage ready/lock status (synchronous to sys_clk)
//   stage_rst_n  : per-stage active-low reset outputs (registered)
//   all_done     : every stage released and ready
//   timeout_err  : sticky timeout fault flag (cleared by soft_reset)
//   fail_stage   : stage index that timed out
//   drop_count   : saturating count of loss-of-ready recoveries
//   cur_stage    : stage currently being sequenced
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int                    NUM_STAGES  = 3,
    parameter int                    CNT_WIDTH   = 16,
    parameter int                    STAGE_DELAY = 200,
    parameter int                    DEBOUNCE    = 4,
    parameter int                    TIMEOUT     = 50000,
    parameter logic [NUM_STAGES-1:0] READY_MASK  = '0
) (
    input  logic                   sys_clk,
    input  logic                   sys_reset_n,
    input  logic                   soft_reset,
    input  logic [NUM_STAGES-1:0]  stage_ready,
    output logic [NUM_STAGES-1:0]  stage_rst_n,
    output logic                   all_done,
    output logic                   timeout_err,
    output logic [STAGE_IDX_W-1:0] fail_stage,
    output logic [DROP_W-1:0]      drop_count,
    output logic [STAGE_IDX_W-1:0] cur_stage
);

    // Parameter sanity checks at elaboration time.
    if (NUM_STAGES < 1 || NUM_STAGES > 16) begin : g_bad_num_stages
        $error("reset_sequencer: NUM_STAGES must be in 1..16");
    end
    if (STAGE_DELAY < 1 || (STAGE_DELAY >> CNT_WIDTH) != 0) begin : g_bad_stage_delay
        $error("reset_sequencer: STAGE_DELAY must be >= 1 and fit in CNT_WIDTH bits");
    end
    if (DEBOUNCE < 1 || (DEBOUNCE >> CNT_WIDTH) != 0) begin : g_bad_debounce
        $error("reset_sequencer: DEBOUNCE must be >= 1 and fit in CNT_WIDTH bits");
    end
    if (TIMEOUT < 0 || (TIMEOUT >> CNT_WIDTH) != 0) begin : g_bad_timeout
        $error("reset_sequencer: TIMEOUT must fit in CNT_WIDTH bits");
    end

    localparam logic [CNT_WIDTH-1:0]   HOLD_LAST  = CNT_WIDTH'(STAGE_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0]   DEB_LAST   = CNT_WIDTH'(DEBOUNCE - 1);
    localparam logic [CNT_WIDTH-1:0]   TO_LAST    = CNT_WIDTH'(TIMEOUT - 1);
    localparam bit                     TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [STAGE_IDX_W-1:0] LAST_STAGE = STAGE_IDX_W'(NUM_STAGES - 1);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    seq_state_t             state_reg,       state_next;
    logic [STAGE_IDX_W-1:0] cur_stage_reg,   cur_stage_next;
    logic [NUM_STAGES-1:0]  stage_rst_n_reg, stage_rst_n_next;
    logic                   all_done_reg,    all_done_next;
    logic                   timeout_err_reg, timeout_err_next;
    logic [STAGE_IDX_W-1:0] fail_stage_reg,  fail_stage_next;

    // Counter controls
    logic                   hold_clr, hold_en;
    logic                   deb_clr,  deb_en;
    logic                   to_clr,   to_en;
    logic                   drop_inc;
    logic [CNT_WIDTH-1:0]   hold_cnt, deb_cnt, to_cnt;

    // Per-stage decode
    logic [NUM_STAGES-1:0]  eff_ready;
    logic [NUM_STAGES-1:0]  cur_onehot;      // bit of the current stage
    logic [NUM_STAGES-1:0]  below_cur;       // stages strictly below cur_stage
    logic [NUM_STAGES-1:0]  completed;       // stages whose ready is monitored
    logic [NUM_STAGES-1:0]  dropped;
    logic [NUM_STAGES-1:0]  below_drop;      // stages strictly below drop_idx
    logic [STAGE_IDX_W-1:0] drop_idx;
    logic                   drop_any;
    logic                   cur_ready;

    assign eff_ready = stage_ready | READY_MASK;

    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
        localparam logic [STAGE_IDX_W-1:0] IDX = STAGE_IDX_W'(gi);
        assign cur_onehot[gi] = (cur_stage_reg == IDX);
        assign below_cur[gi]  = (IDX < cur_stage_reg);
        assign below_drop[gi] = (IDX < drop_idx);
        // In DONE every stage is complete; in HOLD/WAIT only the ones
        // already passed. A faulted sequencer ignores ready entirely.
        assign completed[gi]  = (state_reg == DONE) ||
                                ((state_reg != FAULT) && (IDX < cur_stage_reg));
    end

    assign dropped   = completed & ~eff_ready;
    assign drop_any  = |dropped;
    assign cur_ready = |(eff_ready & cur_onehot);

    // Lowest dropped index wins: scan downward so the last hit is lowest.
    always_comb begin
        drop_idx = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (dropped[i]) begin
                drop_idx = STAGE_IDX_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    sat_counter #(.WIDTH(CNT_WIDTH)) u_hold_cnt (
        .clk   (sys_clk),
        .rst_n (sys_reset_n),
        .clr   (hold_clr),
        .en    (hold_en),
        .count (hold_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_deb_cnt (
        .clk   (sys_clk),
        .rst_n (sys_reset_n),
        .clr   (deb_clr),
        .en    (deb_en),
        .count (deb_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_to_cnt (
        .clk   (sys_clk),
        .rst_n (sys_reset_n),
        .clr   (to_clr),
        .en    (to_en),
        .count (to_cnt)
    );

    // Never cleared except by sys_reset_n; survives soft_reset.
    sat_counter #(.WIDTH(DROP_W)) u_drop_cnt (
        .clk   (sys_clk),
        .rst_n (sys_reset_n),
        .clr   (1'b0),
        .en    (drop_inc),
        .count (drop_count)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (!sys_reset_n) begin
            state_reg       <= HOLD;
            cur_stage_reg   <= '0;
            stage_rst_n_reg <= '0;
            all_done_reg    <= 1'b0;
            timeout_err_reg <= 1'b0;
            fail_stage_reg  <= '0;
        end else begin
            state_reg       <= state_next;
            cur_stage_reg   <= cur_stage_next;
            stage_rst_n_reg <= stage_rst_n_next;
            all_done_reg    <= all_done_next;
            timeout_err_reg <= timeout_err_next;
            fail_stage_reg  <= fail_stage_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state / outputs
    // Priority: soft_reset > loss-of-ready > timeout > normal advance.
    // ------------------------------------------------------------------
    always_comb begin
        state_next       = state_reg;
        cur_stage_next   = cur_stage_reg;
        stage_rst_n_next = stage_rst_n_reg;
        all_done_next    = all_done_reg;
        timeout_err_next = timeout_err_reg;
        fail_stage_next  = fail_stage_reg;
        hold_clr         = 1'b0;
        hold_en          = 1'b0;
        deb_clr          = 1'b0;
        deb_en           = 1'b0;
        to_clr           = 1'b0;
        to_en            = 1'b0;
        drop_inc         = 1'b0;

        if (soft_reset) begin
            state_next       = HOLD;
            cur_stage_next   = '0;
            stage_rst_n_next = '0;
            all_done_next    = 1'b0;
            timeout_err_next = 1'b0;
            hold_clr         = 1'b1;
            deb_clr          = 1'b1;
            to_clr           = 1'b1;
        end else if (drop_any) begin
            // Re-sequence from the lowest stage that lost ready.
            state_next       = HOLD;
            cur_stage_next   = drop_idx;
            stage_rst_n_next = stage_rst_n_reg & below_drop;
            all_done_next    = 1'b0;
            hold_clr         = 1'b1;
            deb_clr          = 1'b1;
            to_clr           = 1'b1;
            drop_inc         = 1'b1;
        end else begin
            case (state_reg)
                HOLD: begin
                    deb_clr = 1'b1;
                    to_clr  = 1'b1;
                    if (hold_cnt == HOLD_LAST) begin
                        stage_rst_n_next = stage_rst_n_reg | cur_onehot;
                        state_next       = WAIT;
                        hold_clr         = 1'b1;
                    end else begin
                        hold_en = 1'b1;
                    end
                end
                WAIT: begin
                    hold_clr = 1'b1;
                    to_en    = 1'b1;
                    // Any low cycle restarts the debounce window.
                    deb_en   = cur_ready;
                    deb_clr  = !cur_ready;
                    if (TIMEOUT_EN && (to_cnt == TO_LAST)) begin
                        state_next       = FAULT;
                        timeout_err_next = 1'b1;
                        fail_stage_next  = cur_stage_reg;
                        stage_rst_n_next = stage_rst_n_reg & below_cur;
                    end else if (cur_ready && (deb_cnt == DEB_LAST)) begin
                        deb_clr = 1'b1;
                        to_clr  = 1'b1;
                        if (cur_stage_reg == LAST_STAGE) begin
                            state_next    = DONE;
                            all_done_next = 1'b1;
                        end else begin
                            state_next     = HOLD;
                            cur_stage_next = cur_stage_reg + 1'b1;
                        end
                    end
                end
                DONE, FAULT: begin
                    hold_clr = 1'b1;
                    deb_clr  = 1'b1;
                    to_clr   = 1'b1;
                end
                default: begin
                    state_next = HOLD;
                end
            endcase
        end
    end

    assign stage_rst_n = stage_rst_n_reg;
    assign all_done    = all_done_reg;
    assign timeout_err = timeout_err_reg;
    assign fail_stage  = fail_stage_reg;
    assign cur_stage   = cur_stage_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer. Two instances: dut_a (no ready mask) and
// dut_m (READY_MASK = 3'b010). Expected output change events (edge number
// and {stage_rst_n, all_done, timeout_err}) are queued as stimulus is
// applied; a monitor per instance pops and compares on every change.
module tb_reset_sequencer;
    import reset_seq_pkg::*;

    localparam int N  = 3;
    localparam int SD = 10;
    localparam int DB = 4;
    localparam int TO = 50;

    typedef struct {
        int         edge_no;
        logic [4:0] val;      // {stage_rst_n[2:0], all_done, timeout_err}
    } ev_t;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int edge_cnt = 0;
    always @(posedge sys_clk) edge_cnt <= edge_cnt + 1;

    int tests_run = 0;
    int tests_failed = 0;

    // Instance A signals
    logic                   rst_n_a, soft_a;
    logic [N-1:0]           ready_a;
    logic [N-1:0]           srst_a;
    logic                   done_a, terr_a;
    logic [STAGE_IDX_W-1:0] fail_a, cur_a;
    logic [DROP_W-1:0]      drop_a;

    // Instance M signals
    logic                   rst_n_m, soft_m;
    logic [N-1:0]           ready_m;
    logic [N-1:0]           srst_m;
    logic                   done_m, terr_m;
    logic [STAGE_IDX_W-1:0] fail_m, cur_m;
    logic [DROP_W-1:0]      drop_m;

    reset_sequencer #(
        .NUM_STAGES(N), .CNT_WIDTH(16), .STAGE_DELAY(SD),
        .DEBOUNCE(DB), .TIMEOUT(TO), .READY_MASK(3'b000)
    ) dut_a (
        .sys_clk     (sys_clk),
        .sys_reset_n (rst_n_a),
        .soft_reset  (soft_a),
        .stage_ready (ready_a),
        .stage_rst_n (srst_a),
        .all_done    (done_a),
        .timeout_err (terr_a),
        .fail_stage  (fail_a),
        .drop_count  (drop_a),
        .cur_stage   (cur_a)
    );

    reset_sequencer #(
        .NUM_STAGES(N), .CNT_WIDTH(16), .STAGE_DELAY(SD),
        .DEBOUNCE(DB), .TIMEOUT(TO), .READY_MASK(3'b010)
    ) dut_m (
        .sys_clk     (sys_clk),
        .sys_reset_n (rst_n_m),
        .soft_reset  (soft_m),
        .stage_ready (ready_m),
        .stage_rst_n (srst_m),
        .all_done    (done_m),
        .timeout_err (terr_m),
        .fail_stage  (fail_m),
        .drop_count  (drop_m),
        .cur_stage   (cur_m)
    );

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Advance to the negedge following posedge number e.
    task automatic goto_edge(input int e);
        while (edge_cnt < e) @(negedge sys_clk);
    endtask

    ev_t        sb_a[$];
    ev_t        sb_m[$];
    bit         mon_en = 1'b0;
    logic [4:0] last_a = '0;
    logic [4:0] last_m = '0;

    always @(negedge sys_clk) begin
        if (mon_en) begin
            logic [4:0] now_v;
            ev_t        e;
            now_v = {srst_a, done_a, terr_a};
            if (now_v !== last_a) begin
                if (sb_a.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL a_unexpected: edge %0d value 0x%0h, no change expected", edge_cnt, now_v);
                end else begin
                    e = sb_a.pop_front();
                    check("a_event_edge", edge_cnt, e.edge_no);
                    check("a_event_value", int'(now_v), int'(e.val));
                    $display("[TB] A edge %0d: stage_rst_n=%b all_done=%b timeout_err=%b",
                             edge_cnt, now_v[4:2], now_v[1], now_v[0]);
                end
                last_a = now_v;
            end
        end
    end

    always @(negedge sys_clk) begin
        if (mon_en) begin
            logic [4:0] now_v;
            ev_t        e;
            now_v = {srst_m, done_m, terr_m};
            if (now_v !== last_m) begin
                if (sb_m.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL m_unexpected: edge %0d value 0x%0h, no change expected", edge_cnt, now_v);
                end else begin
                    e = sb_m.pop_front();
                    check("m_event_edge", edge_cnt, e.edge_no);
                    check("m_event_value", int'(now_v), int'(e.val));
                    $display("[TB] M edge %0d: stage_rst_n=%b all_done=%b timeout_err=%b",
                             edge_cnt, now_v[4:2], now_v[1], now_v[0]);
                end
                last_m = now_v;
            end
        end
    end

    // Global watchdog
    always @(posedge sys_clk) begin
        if (edge_cnt > 5000) begin
            $display("FAIL watchdog: edge %0d exceeded budget", edge_cnt);
            $fatal(1, "watchdog expired");
        end
    end

    // Queue a normal full sequence whose first counting edge is start+1.
    task automatic push_seq_a(input int start);
        sb_a.push_back('{start + 10, 5'b001_0_0});
        sb_a.push_back('{start + 24, 5'b011_0_0});
        sb_a.push_back('{start + 38, 5'b111_0_0});
        sb_a.push_back('{start + 42, 5'b111_1_0});
    endtask

    initial begin
        int base;
        int s;
        int d;

        rst_n_a = 1'b0; soft_a = 1'b0; ready_a = 3'b111;
        rst_n_m = 1'b0; soft_m = 1'b0; ready_m = 3'b101;
        repeat (3) @(negedge sys_clk);

        // Reset state
        check("rst_stage_rst_n", int'(srst_a), 0);
        check("rst_all_done",    int'(done_a), 0);
        check("rst_timeout_err", int'(terr_a), 0);
        check("rst_fail_stage",  int'(fail_a), 0);
        check("rst_drop_count",  int'(drop_a), 0);
        check("rst_cur_stage",   int'(cur_a),  0);
        check("rst_m_stage_rst_n", int'(srst_m), 0);
        mon_en = 1'b1;

        // 1: all ready, release at 10/24/38, done at 42
        base = edge_cnt;
        rst_n_a = 1'b1;
        push_seq_a(base);
        goto_edge(base + 44);
        check("t1_drop_count", int'(drop_a), 0);
        check("t1_cur_stage",  int'(cur_a),  2);

        // 2: stage 1 never ready -> FAULT at 74
        rst_n_a = 1'b0;
        ready_a = 3'b101;
        sb_a.push_back('{edge_cnt + 1, 5'b000_0_0});
        goto_edge(edge_cnt + 2);
        base = edge_cnt;
        rst_n_a = 1'b1;
        sb_a.push_back('{base + 10, 5'b001_0_0});
        sb_a.push_back('{base + 24, 5'b011_0_0});
        sb_a.push_back('{base + 74, 5'b001_0_1});
        goto_edge(base + 76);
        check("t2_fail_stage", int'(fail_a), 1);
        check("t2_cur_stage",  int'(cur_a),  1);

        // 3: soft_reset out of FAULT, sequence replays
        ready_a = 3'b111;
        soft_a  = 1'b1;
        s = edge_cnt + 1;
        sb_a.push_back('{s, 5'b000_0_0});
        push_seq_a(s);
        goto_edge(s);
        soft_a = 1'b0;
        check("t3_cur_stage", int'(cur_a), 0);
        goto_edge(s + 44);
        check("t3_drop_count", int'(drop_a), 0);

        // 4: one-cycle drop of stage 1 in DONE
        ready_a = 3'b101;
        d = edge_cnt + 1;
        sb_a.push_back('{d,      5'b001_0_0});
        sb_a.push_back('{d + 10, 5'b011_0_0});
        sb_a.push_back('{d + 24, 5'b111_0_0});
        sb_a.push_back('{d + 28, 5'b111_1_0});
        goto_edge(d);
        ready_a = 3'b111;
        check("t4_drop_count", int'(drop_a), 1);
        check("t4_cur_stage",  int'(cur_a),  1);
        goto_edge(d + 30);

        // 5: simultaneous drop of stages 0 and 2 -> restart from 0
        ready_a = 3'b010;
        d = edge_cnt + 1;
        sb_a.push_back('{d, 5'b000_0_0});
        push_seq_a(d);
        goto_edge(d);
        ready_a = 3'b111;
        check("t5_drop_count", int'(drop_a), 2);
        check("t5_cur_stage",  int'(cur_a),  0);
        goto_edge(d + 44);

        // 6: masked stage 1, debounce restart on stage 0 glitch
        base = edge_cnt;
        rst_n_m = 1'b1;
        sb_m.push_back('{base + 10, 5'b001_0_0});
        sb_m.push_back('{base + 27, 5'b011_0_0});
        sb_m.push_back('{base + 41, 5'b111_0_0});
        sb_m.push_back('{base + 45, 5'b111_1_0});
        goto_edge(base + 12);
        ready_m = 3'b100;
        goto_edge(base + 13);
        ready_m = 3'b101;
        goto_edge(base + 47);
        check("t6_drop_count",  int'(drop_m), 0);
        check("t6_timeout_err", int'(terr_m), 0);

        check("sb_a_empty", sb_a.size(), 0);
        check("sb_m_empty", sb_m.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
